// File: rtl/fp8_e4m3_encoder.sv
// Fixed-point (20-bit, LSB = 2^-9) to FP8 E4M3 encoder: one-bit-per-cycle normalize, RNE round.
// FP8ENC_SAT_EN: when defined, overflow saturates to +/-448; otherwise overflow yields NaN.
module fp8_e4m3_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_ovf
);

`ifdef FP8ENC_SAT_EN
    localparam logic [6:0] OVF_CODE = 7'h7E;
`else
    localparam logic [6:0] OVF_CODE = 7'h7F;
`endif

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state, state_nx;
    logic        sign;
    logic [19:0] sh;
    logic [4:0]  p;

    logic [19:0] abs_in;
    logic        norm_stop;
    logic [4:0]  e_base, e_rnd;
    logic [2:0]  m_base, m_rnd;
    logic [3:0]  m_sum;
    logic        g_bit, t_bit, rnd_up, ovf;
    logic [7:0]  res;

    // Magnitude is 20-bit unsigned so -2^19 maps cleanly to 0x80000.
    assign abs_in    = in_data[19] ? (~in_data + 20'd1) : in_data;
    assign in_ready  = (state == IDLE);
    assign norm_stop = sh[19] | (p == 5'd3);

    always_comb begin
        e_base = sh[19] ? (p - 5'd2) : 5'd0;
        m_base = sh[18:16];
        g_bit  = sh[15];
        t_bit  = |sh[14:0];
        rnd_up = g_bit & (t_bit | m_base[0]);
        m_sum  = {1'b0, m_base} + {3'b000, rnd_up};
        // Mantissa carry-out bumps the exponent; the zeroed mantissa is m_sum[2:0].
        e_rnd  = e_base + {4'b0000, m_sum[3]};
        m_rnd  = m_sum[2:0];
        ovf    = (e_rnd >= 5'd16) | ((e_rnd == 5'd15) & (m_rnd == 3'b111));
        res    = ovf ? {sign, OVF_CODE} : {sign & (|sh), e_rnd[3:0], m_rnd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = NORM;
            NORM:    if (norm_stop) state_nx = ROUND;
            ROUND:                  state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign      <= 1'b0;
            sh        <= '0;
            p         <= 5'd19;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign <= in_data[19];
                    sh   <= abs_in;
                    p    <= 5'd19;
                end
                NORM: if (!norm_stop) begin
                    sh <= sh << 1;
                    p  <= p - 5'd1;
                end
                ROUND: begin
                    out_data  <= res;
                    out_ovf   <= ovf;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_e4m3_encoder.sv
// Bench for fp8_e4m3_encoder: directed + random conversions against a code-table nearest-even model.
module tb_fp8_e4m3_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_ovf;

    int errs   = 0;
    int checks = 0;

    fp8_e4m3_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Magnitude of E4M3 code c (0..127) in units of 2^-9; code 127 stands in for 480.
    function automatic int code_val(input int c);
        int e, m;
        e = c >> 3;
        m = c & 7;
        if (e == 0) return m;
        return (8 + m) << (e - 1);
    endfunction

    function automatic void model(input logic [19:0] x, output logic [7:0] d,
                                  output logic o, output int lat);
        int a, c, dl, dh, msb;
        logic s;
        s = x[19];
        a = s ? (1 << 20) - int'(x) : int'(x);
        msb = -1;
        for (int i = 0; i < 20; i++) if ((a >> i) & 1) msb = i;
        lat = 19 - ((msb > 3) ? msb : 3) + 2;
        o = 1'b0;
        c = 0;
        if (a >= code_val(127)) o = 1'b1;
        else begin
            for (int i = 0; i < 128; i++) if (code_val(i) <= a) c = i;
            if (code_val(c) != a) begin
                dl = a - code_val(c);
                dh = code_val(c + 1) - a;
                if (dh < dl || (dh == dl && (c & 1))) c = c + 1;
            end
            if (c == 127) o = 1'b1;
        end
`ifdef FP8ENC_SAT_EN
        if (o) d = {s, 7'h7E};
`else
        if (o) d = {s, 7'h7F};
`endif
        else d = {s & (a != 0), 7'(c)};
    endfunction

    // Accept x, check latency/result, hold out_ready low for `hold` cycles, then hand off.
    task automatic convert(input logic [19:0] x, input int hold, input string tag);
        logic [7:0] ed;
        logic eo, rdy_low;
        int el, cyc;
        model(x, ed, eo, el);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        cyc = 0;
        rdy_low = 1'b1;
        while (!out_valid && cyc < 40) begin
            if (in_ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " valid"}, int'(out_valid), 1);
        chk({tag, " latency"}, cyc, el);
        chk({tag, " data"}, int'(out_data), int'(ed));
        chk({tag, " ovf"}, int'(out_ovf), int'(eo));
        chk({tag, " in_ready busy"}, int'(rdy_low), 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 20'h00200;
        end
        if (hold > 0) begin
            chk({tag, " held data"}, int'(out_data), int'(ed));
            chk({tag, " held valid"}, int'(out_valid), 1);
            chk({tag, " held in_ready"}, int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " release valid"}, int'(out_valid), 0);
        chk({tag, " release in_ready"}, int'(in_ready), 1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [19:0] x;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset out_ovf", int'(out_ovf), 0);
        chk("reset in_ready", int'(in_ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        convert(20'd0, 0, "zero");
        convert(20'd512, 0, "one");
        convert(-20'sd3, 0, "neg3");
        convert(20'd15, 0, "fifteen");
        convert(20'd544, 0, "tie_even");
        convert(20'd608, 0, "tie_odd");
        convert(20'd545, 0, "above_tie");
        convert(20'h03C00, 0, "x3c00");
        convert(20'd7936, 0, "carry_e");
        convert(20'd229376, 0, "max448");
        convert(20'd237568, 0, "tie464");
        convert(20'd237569, 0, "ovf_pos");
        convert(20'h80000, 0, "ovf_minneg");
        convert(20'h00400, 5, "backpressure");

        for (int n = 0; n < 24; n++) begin
            x = 20'($urandom >> $urandom_range(31, 12));
            if ($urandom_range(1, 0)) x = -x;
            convert(x, $urandom_range(2, 0), "random");
        end

        // Asynchronous reset in the middle of normalization.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 20'd1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async out_valid", int'(out_valid), 0);
        chk("async out_data", int'(out_data), 0);
        chk("async in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        convert(20'd512, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
